// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
// Mode encoding, rate index type and half-period arithmetic.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STEADY = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_BURST  = 2'b11
    } mode_t;

    typedef logic [1:0] rate_t;

    function automatic longint unsigned half_period(
        input longint unsigned clk_hz,
        input longint unsigned rate_hz
    );
        if (rate_hz == 0) return 0;
        return clk_hz / (2 * rate_hz);
    endfunction

    function automatic bit rate_ok(
        input longint unsigned clk_hz,
        input longint unsigned rate_hz,
        input int              cnt_w
    );
        longint unsigned hp;
        if (rate_hz == 0) return 1'b0;
        hp = clk_hz / (2 * rate_hz);
        if (clk_hz % (2 * rate_hz) != 0) return 1'b0;
        if (hp < 1) return 1'b0;
        if (cnt_w >= 64) return 1'b1;
        return hp < (64'd1 << cnt_w);
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: half-period counter, phase and optional burst state.
// Burst pulse/gap logic exists only with LED_BLINKER_BURST_EN defined.
module led_channel
    import led_pkg::*;
#(
    parameter int CNT_W = 32
`ifdef LED_BLINKER_BURST_EN
    ,
    parameter int BURST_LEN = 3,
    parameter int BURST_GAP = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [1:0]       wr_mode,
    input  logic [1:0]       wr_rate,
    input  logic [CNT_W-1:0] max,
    output logic [1:0]       rate,
    output logic             on
);

    mode_t            mode;
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             run;
    logic             tc;

    assign run = (mode == MODE_BLINK) || (mode == MODE_BURST);
    assign tc  = (cnt == max - CNT_W'(1));

`ifdef LED_BLINKER_BURST_EN
    localparam int PW = $clog2(BURST_LEN + 1);
    localparam int GW = $clog2(BURST_GAP + 1);

    logic [PW-1:0] pulses;
    logic [GW-1:0] gcnt;
    logic          gap;

    // Load on write, otherwise count half-periods and sequence burst/gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode   <= MODE_OFF;
            rate   <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
            pulses <= '0;
            gcnt   <= '0;
            gap    <= 1'b0;
        end else if (wr) begin
            mode   <= mode_t'(wr_mode);
            rate   <= wr_rate;
            cnt    <= '0;
            phase  <= 1'b0;
            pulses <= '0;
            gcnt   <= '0;
            gap    <= 1'b0;
        end else if (!run) begin
            cnt    <= '0;
            phase  <= 1'b0;
            pulses <= '0;
            gcnt   <= '0;
            gap    <= 1'b0;
        end else if (tc) begin
            cnt <= '0;
            if (gap) begin
                if (gcnt == GW'(BURST_GAP - 1)) begin
                    gap    <= 1'b0;
                    gcnt   <= '0;
                    pulses <= '0;
                end else begin
                    gcnt <= gcnt + GW'(1);
                end
            end else if (phase) begin
                phase <= 1'b0;
                if (mode == MODE_BURST) begin
                    pulses <= pulses + PW'(1);
                    if (pulses == PW'(BURST_LEN - 1)) gap <= 1'b1;
                end
            end else begin
                phase <= 1'b1;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign on = (mode == MODE_STEADY) || (run && phase && !gap);
`else
    // Load on write, otherwise toggle phase every half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode  <= MODE_OFF;
            rate  <= '0;
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wr) begin
            mode  <= mode_t'(wr_mode);
            rate  <= wr_rate;
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tc) begin
            cnt   <= '0;
            phase <= !phase;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign on = (mode == MODE_STEADY) || (run && phase);
`endif

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker: write decode, rate lookup, output register.
// Burst mode is built only when LED_BLINKER_BURST_EN is defined.
module led_blinker_multi
    import led_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned RATE0_HZ  = 1,
    parameter int unsigned RATE1_HZ  = 5,
    parameter int unsigned RATE2_HZ  = 10,
    parameter int unsigned RATE3_HZ  = 20,
    parameter int unsigned BURST_LEN = 3,
    parameter int unsigned BURST_GAP = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_cfg_wr,
    input  logic [3:0]        i_cfg_ch,
    input  logic [1:0]        i_cfg_mode,
    input  logic [1:0]        i_cfg_rate,
    output logic [NUM_CH-1:0] o_led
);

    localparam longint unsigned MAX0 = half_period(CLK_HZ, RATE0_HZ);
    localparam longint unsigned MAX1 = half_period(CLK_HZ, RATE1_HZ);
    localparam longint unsigned MAX2 = half_period(CLK_HZ, RATE2_HZ);
    localparam longint unsigned MAX3 = half_period(CLK_HZ, RATE3_HZ);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be 1..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
    if (!rate_ok(CLK_HZ, RATE0_HZ, CNT_W) ||
        !rate_ok(CLK_HZ, RATE1_HZ, CNT_W) ||
        !rate_ok(CLK_HZ, RATE2_HZ, CNT_W) ||
        !rate_ok(CLK_HZ, RATE3_HZ, CNT_W)) begin : g_bad_rate
        $error("each rate must give an integral half-period in range");
    end
    if (BURST_LEN < 1 || BURST_GAP < 1) begin : g_bad_burst
        $error("BURST_LEN and BURST_GAP must be at least 1");
    end

    logic [NUM_CH-1:0] on;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             wr;
        logic [1:0]       rate;
        logic [CNT_W-1:0] max;
        logic             on_c;

        assign wr    = i_cfg_wr && (i_cfg_ch == 4'(c));
        assign on[c] = on_c;

        // Map the channel's stored rate index to its half-period count.
        always_comb begin
            max = CNT_W'(MAX0);
            unique case (rate)
                2'd0: max = CNT_W'(MAX0);
                2'd1: max = CNT_W'(MAX1);
                2'd2: max = CNT_W'(MAX2);
                2'd3: max = CNT_W'(MAX3);
            endcase
        end

        led_channel #(
            .CNT_W(CNT_W)
`ifdef LED_BLINKER_BURST_EN
            ,
            .BURST_LEN(BURST_LEN),
            .BURST_GAP(BURST_GAP)
`endif
        ) u_ch (
            .clk    (i_clk),
            .rst    (i_rst),
            .wr     (wr),
            .wr_mode(i_cfg_mode),
            .wr_rate(i_cfg_rate),
            .max    (max),
            .rate   (rate),
            .on     (on_c)
        );
    end

    // Register the gated LED drive so pins see glitch-free levels.
    always_ff @(posedge i_clk) begin
        if (i_rst) o_led <= '0;
        else       o_led <= i_enable ? on : '0;
    end

endmodule
